// File: rtl/johnson_monitor.sv
// rtl/johnson_monitor.sv - Johnson (twisted-ring) pattern checker: decode, successor check, rotation/error/stall tracking
module johnson_monitor #(
    parameter int WIDTH   = 10,
    parameter int CYCLE_W = 8,
    parameter int ERR_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          EN,
    input  logic [WIDTH-1:0]              PATTERN_IN,
    input  logic                          CLR_ERR,
    output logic [$clog2(2*WIDTH)-1:0]    STEP_IDX,
    output logic                          VALID,
    output logic                          STEP,
    output logic                          WRAP,
    output logic [CYCLE_W-1:0]            CYCLE_CNT,
    output logic                          ERR,
    output logic [ERR_W-1:0]              ERR_CNT,
    output logic                          STALL
);

    localparam int SEQ_LEN = 2 * WIDTH;
    localparam int IDX_W   = $clog2(SEQ_LEN);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     cap_q;
    logic                 cap_vld_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 step_q, step_d;
    logic                 wrap_q, wrap_d;
    logic [CYCLE_W-1:0]   cyc_q, cyc_d;
    logic                 err_q, err_d;
    logic [ERR_W-1:0]     ecnt_q, ecnt_d;
    logic [STALL_W-1:0]   scnt_q, scnt_d;
    logic                 stall_q, stall_d;
    logic                 log_err;
    logic                 dec_legal;
    logic [IDX_W-1:0]     dec_idx;
    logic [IDX_W-1:0]     succ_idx;

    // Code for step k: k ones filling from bit 0, then zeros filling from bit 0.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        for (int i = 0; i < WIDTH; i++) begin
            c[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
        end
        return c;
    endfunction

    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (cap_q == code_of(k)) begin
                dec_legal = 1'b1;
                dec_idx   = IDX_W'(k);
            end
        end
    end

    assign succ_idx = (idx_q == IDX_W'(SEQ_LEN - 1)) ? '0 : idx_q + 1'b1;

    // Evaluation follows the capture by one clock, so a pattern captured
    // just before EN drops still gets judged.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        cyc_d   = cyc_q;
        scnt_d  = scnt_q;
        log_err = 1'b0;
        if (cap_vld_q) begin
            case (state_q)
                IDLE, FAULT: begin
                    scnt_d = '0;
                    if (dec_legal) begin
                        state_d = TRACK;
                        idx_d   = dec_idx;
                        valid_d = 1'b1;
                    end else if (state_q == IDLE) begin
                        state_d = FAULT;
                        log_err = 1'b1;
                    end
                end
                TRACK: begin
                    if (!dec_legal) begin
                        state_d = FAULT;
                        valid_d = 1'b0;
                        scnt_d  = '0;
                        log_err = 1'b1;
                    end else if (dec_idx == idx_q) begin
                        if (scnt_q != STALL_W'(TIMEOUT)) begin
                            scnt_d = scnt_q + 1'b1;
                        end
                    end else if (dec_idx == succ_idx) begin
                        step_d = 1'b1;
                        idx_d  = dec_idx;
                        scnt_d = '0;
                        if (dec_idx == '0) begin
                            wrap_d = 1'b1;
                            cyc_d  = cyc_q + 1'b1;
                        end
                    end else begin
                        idx_d   = dec_idx;
                        scnt_d  = '0;
                        log_err = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        stall_d = (state_d == TRACK) && (scnt_d == STALL_W'(TIMEOUT));
    end

    // A fresh error outranks a simultaneous clear and restarts the count at one.
    always_comb begin
        err_d  = err_q;
        ecnt_d = ecnt_q;
        if (log_err) begin
            err_d  = 1'b1;
            ecnt_d = CLR_ERR ? ERR_W'(1) : ((ecnt_q == '1) ? ecnt_q : ecnt_q + 1'b1);
        end else if (CLR_ERR) begin
            err_d  = 1'b0;
            ecnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cyc_q     <= '0;
            err_q     <= 1'b0;
            ecnt_q    <= '0;
            scnt_q    <= '0;
            stall_q   <= 1'b0;
        end else begin
            if (EN) begin
                cap_q <= PATTERN_IN;
            end
            cap_vld_q <= EN;
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
            cyc_q     <= cyc_d;
            err_q     <= err_d;
            ecnt_q    <= ecnt_d;
            scnt_q    <= scnt_d;
            stall_q   <= stall_d;
        end
    end

    assign STEP_IDX  = idx_q;
    assign VALID     = valid_q;
    assign STEP      = step_q;
    assign WRAP      = wrap_q;
    assign CYCLE_CNT = cyc_q;
    assign ERR       = err_q;
    assign ERR_CNT   = ecnt_q;
    assign STALL     = stall_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// tb/tb_johnson_monitor.sv - scoreboard bench for johnson_monitor with directed Johnson-code vectors
module tb_johnson_monitor;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic [9:0] PATTERN_IN = '0;
    logic       CLR_ERR = 1'b0;
    logic [4:0] STEP_IDX;
    logic       VALID, STEP, WRAP, ERR, STALL;
    logic [7:0] CYCLE_CNT;
    logic [3:0] ERR_CNT;

    johnson_monitor dut (
        .CLK(CLK), .RST(RST), .EN(EN), .PATTERN_IN(PATTERN_IN), .CLR_ERR(CLR_ERR),
        .STEP_IDX(STEP_IDX), .VALID(VALID), .STEP(STEP), .WRAP(WRAP),
        .CYCLE_CNT(CYCLE_CNT), .ERR(ERR), .ERR_CNT(ERR_CNT), .STALL(STALL)
    );

    always #5 CLK = ~CLK;

    typedef enum int {K_VALID, K_IDX, K_STEP, K_WRAP, K_CYC, K_ERR, K_ECNT, K_STALL, K_NSTEP, K_NWRAP} chk_e;
    typedef struct {
        int          due;
        chk_e        kind;
        int unsigned val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   step_seen = 0;
    int   wrap_seen = 0;

    logic [9:0] codes [20] = '{
        10'b0000000000, 10'b0000000001, 10'b0000000011, 10'b0000000111, 10'b0000001111,
        10'b0000011111, 10'b0000111111, 10'b0001111111, 10'b0011111111, 10'b0111111111,
        10'b1111111111, 10'b1111111110, 10'b1111111100, 10'b1111111000, 10'b1111110000,
        10'b1111100000, 10'b1111000000, 10'b1110000000, 10'b1100000000, 10'b1000000000
    };
    logic [9:0] bad_code = 10'b0000000101;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: tallies pulses, then retires every expectation due this cycle.
    always @(negedge CLK) begin
        int unsigned got;
        if (STEP) step_seen++;
        if (WRAP) wrap_seen++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                case (sb[i].kind)
                    K_VALID: got = VALID;
                    K_IDX:   got = STEP_IDX;
                    K_STEP:  got = STEP;
                    K_WRAP:  got = WRAP;
                    K_CYC:   got = CYCLE_CNT;
                    K_ERR:   got = ERR;
                    K_ECNT:  got = ERR_CNT;
                    K_STALL: got = STALL;
                    K_NSTEP: got = step_seen;
                    default: got = wrap_seen;
                endcase
                checks++;
                if (sb[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
                end else if (got != sb[i].val) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[i].name, got, sb[i].val, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic want(input int dly, input chk_e k, input int unsigned v, input string nm);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int last;
        tick(2);
        want(0, K_VALID, 0, "rst_valid");
        want(0, K_IDX, 0, "rst_idx");
        want(0, K_CYC, 0, "rst_cyc");
        want(0, K_ERR, 0, "rst_err");
        want(0, K_ECNT, 0, "rst_ecnt");
        want(0, K_STALL, 0, "rst_stall");
        want(0, K_STEP, 0, "rst_step");

        // Acquire at idx 0
        RST = 1'b0; EN = 1'b1; PATTERN_IN = codes[0];
        want(1, K_VALID, 0, "acq_latency");
        want(2, K_VALID, 1, "acq_valid");
        want(2, K_IDX, 0, "acq_idx");
        want(2, K_STEP, 0, "acq_nostep");
        want(2, K_CYC, 0, "acq_cyc");
        want(2, K_ERR, 0, "acq_err");
        tick(4);

        // Full rotation, 10 clocks per code
        for (int k = 1; k <= 20; k++) begin
            PATTERN_IN = codes[k % 20];
            want(2, K_STEP, 1, "rot_step");
            want(2, K_IDX, k % 20, "rot_idx");
            want(3, K_STEP, 0, "rot_step_pulse");
            want(2, K_WRAP, (k == 20) ? 1 : 0, "rot_wrap");
            if (k == 20) want(2, K_CYC, 1, "rot_cyc");
            want(9, K_STALL, 0, "rot_nostall");
            tick(10);
        end
        want(0, K_NSTEP, 20, "rot_step_count");
        want(0, K_NWRAP, 1, "rot_wrap_count");
        want(0, K_ERR, 0, "rot_err");

        for (int k = 1; k <= 2; k++) begin
            PATTERN_IN = codes[k];
            want(2, K_STEP, 1, "pre3_step");
            want(2, K_IDX, k, "pre3_idx");
            tick(4);
        end

        // Illegal code from TRACK, then recovery
        PATTERN_IN = bad_code;
        want(2, K_ERR, 1, "ill_err");
        want(2, K_ECNT, 1, "ill_ecnt");
        want(2, K_VALID, 0, "ill_valid");
        want(2, K_IDX, 2, "ill_idx_hold");
        want(2, K_STEP, 0, "ill_nostep");
        tick(4);
        PATTERN_IN = codes[3];
        want(2, K_VALID, 1, "rec_valid");
        want(2, K_IDX, 3, "rec_idx");
        want(2, K_STEP, 0, "rec_nostep");
        want(2, K_ERR, 1, "rec_err_sticky");
        tick(4);

        // Stall: 20-clock hold at idx 4
        PATTERN_IN = codes[4];
        want(2, K_STEP, 1, "st4_step");
        want(16, K_STALL, 0, "st4_early");
        want(17, K_STALL, 1, "st4_stall");
        want(19, K_STALL, 1, "st4_level");
        tick(20);
        // Same hold at idx 5 with a 10-clock EN gap
        PATTERN_IN = codes[5];
        want(2, K_STEP, 1, "st5_step");
        want(2, K_STALL, 0, "st5_clear");
        want(2, K_IDX, 5, "st5_idx");
        want(12, K_IDX, 5, "st5_en0_idx");
        want(12, K_STEP, 0, "st5_en0_step");
        want(16, K_STALL, 0, "st5_not_yet");
        want(26, K_STALL, 0, "st5_delayed");
        want(27, K_STALL, 1, "st5_stall");
        tick(5);
        EN = 1'b0;
        tick(10);
        EN = 1'b1;
        tick(15);
        PATTERN_IN = codes[6];
        want(1, K_STALL, 1, "st6_before");
        want(2, K_STALL, 0, "st6_cleared");
        want(2, K_STEP, 1, "st6_step");
        want(2, K_IDX, 6, "st6_idx");
        tick(4);

        // Reset mid-rotation, then re-acquire at idx 2
        RST = 1'b1;
        want(1, K_VALID, 0, "mr_valid");
        want(1, K_IDX, 0, "mr_idx");
        want(1, K_CYC, 0, "mr_cyc");
        want(1, K_ERR, 0, "mr_err");
        want(1, K_ECNT, 0, "mr_ecnt");
        want(1, K_STALL, 0, "mr_stall");
        tick(1);
        RST = 1'b0; PATTERN_IN = codes[2];
        want(1, K_VALID, 0, "reacq_latency");
        want(2, K_VALID, 1, "reacq_valid");
        want(2, K_IDX, 2, "reacq_idx");
        want(2, K_STEP, 0, "reacq_nostep");
        tick(4);

        // Skip 2 -> 5, then legal 5 -> 6
        PATTERN_IN = codes[5];
        want(2, K_ERR, 1, "skip_err");
        want(2, K_ECNT, 1, "skip_ecnt");
        want(2, K_IDX, 5, "skip_idx");
        want(2, K_STEP, 0, "skip_nostep");
        want(2, K_VALID, 1, "skip_valid");
        tick(4);
        PATTERN_IN = codes[6];
        want(2, K_STEP, 1, "after_skip_step");
        want(2, K_IDX, 6, "after_skip_idx");
        want(2, K_ECNT, 1, "after_skip_ecnt");
        tick(4);

        // Clear coinciding with an error: error wins, count restarts at 1
        PATTERN_IN = bad_code;
        tick(1);
        CLR_ERR = 1'b1;
        want(1, K_ERR, 1, "clr_vs_err_err");
        want(1, K_ECNT, 1, "clr_vs_err_ecnt");
        want(1, K_VALID, 0, "clr_vs_err_valid");
        tick(1);
        CLR_ERR = 1'b0;
        tick(2);
        PATTERN_IN = codes[7];
        want(2, K_VALID, 1, "fault_reacq_valid");
        want(2, K_IDX, 7, "fault_reacq_idx");
        want(2, K_STEP, 0, "fault_reacq_nostep");
        tick(4);
        CLR_ERR = 1'b1;
        want(1, K_ERR, 0, "clr_err");
        want(1, K_ECNT, 0, "clr_ecnt");
        tick(1);
        CLR_ERR = 1'b0;
        tick(2);

        // 256 rotations at one code per clock: CYCLE_CNT 255 -> 0
        last = 13 + 20 * 255;
        for (int i = 1; i <= last; i++) begin
            PATTERN_IN = codes[(7 + i) % 20];
            if (i == 13 + 20 * 254) want(2, K_CYC, 255, "cyc_255");
            if (i == last) begin
                want(2, K_CYC, 0, "cyc_wrap0");
                want(2, K_WRAP, 1, "cyc_wrap_pulse");
                want(2, K_ERR, 0, "cyc_wrap_noerr");
                want(2, K_STALL, 0, "cyc_wrap_nostall");
            end
            tick(1);
        end
        tick(4);

        // Alternating idx 10 / idx 0 is an error every clock: saturate ERR_CNT
        for (int i = 0; i < 18; i++) begin
            PATTERN_IN = (i % 2 == 0) ? codes[10] : codes[0];
            if (i == 13) want(2, K_ECNT, 14, "sat_14");
            if (i == 17) begin
                want(2, K_ECNT, 15, "sat_15");
                want(2, K_ERR, 1, "sat_err");
                want(2, K_STEP, 0, "sat_nostep");
            end
            tick(1);
        end
        tick(10);
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors + sb.size());
        $finish;
    end

endmodule
